cluster_map_serializer: RTL and testbench
=========================================

# cluster_map_serializer

Downstream stage of the per-crate mapping blocks. It captures one complete hit-map frame: a 38-bit header plus 38 rows of 38 bits, which the mapper presents for a single cycle. It then streams the frame out one 38-bit word per handshake toward the cluster-finder link. It counts hits on the fly and drops and counts any frame that arrives while a previous frame is still streaming.

## Interface
Parameters:
- ROWS, 38, rows per frame.
- WIDTH, 38, bits per row, header and trailer word.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- map_hdr  in  WIDTH  mapper header; bit 37 = frame strobe, [25:16] = fiber id, [15:0] = sync pattern 16'hAAAA.
- map_rows  in  ROWS*WIDTH  flattened rows; row i = [WIDTH*i+WIDTH-1 : WIDTH*i].
- dout  out  WIDTH  output word.
- dout_valid  out  1  word valid.
- dout_ready  in  1  downstream accepts when valid && ready.
- dout_sof  out  1  high with the header word.
- dout_eof  out  1  high with the last word of the frame.
- busy  out  1  frame buffered and not fully sent.
- drop_cnt  out  16  frames dropped; saturates at 16'hFFFF.

## Operation
- Frame strobe: map_hdr[37]==1. On strobe when not busy, or when the eof word is accepted in the same cycle, latch map_hdr and all rows into the frame buffer.
- On strobe while busy (and not at an eof handshake): ignore the frame and increment drop_cnt.
- FSM states:
  - IDLE: on capture, go to HDR.
  - HDR: dout = latched header, sof=1. On handshake, row_idx=0 and go to ROWS.
  - ROWS: dout = row[row_idx]. On handshake, increment row_idx. At row_idx==ROWS-1, go to TRL if the macro is defined, else go to IDLE (eof on that row).
  - TRL: dout = trailer word, eof=1. On handshake, go to IDLE.
- A capture coincident with the eof handshake goes directly to HDR; there is no idle gap.
- Hit counter: 11 bits, cleared on capture. On each row handshake, add popcount(row). Maximum 1444, so no overflow.
- Trailer format: [37]=1, [36:26]=11'h7FF, [25:16]=latched fiber id, [15:11]=0, [10:0]=hit count.
- busy=1 in HDR, ROWS and TRL.
- dout is 0 whenever dout_valid is 0.
- While dout_valid && !dout_ready, dout, sof and eof hold stable.

## Timing
- Reset values: dout=0, dout_valid=0, dout_sof=0, dout_eof=0, busy=0, drop_cnt=0, state IDLE, buffer cleared.
- Strobe sampled at edge t: dout_valid=1 with the header from cycle t+1.
- With dout_ready tied high:
  - 40 cycles header-to-eof with the trailer (header + 38 rows + trailer).
  - 39 cycles without the trailer.
- Back-to-back frames give continuous valid with no bubble.
- rst mid-frame: at the next edge all outputs reach reset values and the partial frame is discarded without counting a drop.
- Strobe and rst in the same cycle: rst wins and the frame is not captured.
- The strobe is level-sampled per cycle. The mapper guarantees a one-cycle pulse; a multi-cycle strobe counts each cycle as a new frame.
- All outputs are registered; there is no combinational path from dout_ready to any output.

## Configuration
- CLUSTER_MAP_TRAILER_EN defined:
  - Hit counter and TRL state present.
  - eof on the trailer.
  - 40 words per frame.
- Undefined:
  - No hit counter and no TRL.
  - eof on row ROWS-1.
  - 39 words per frame.
  - Popcount logic not instantiated.

## Structure
- Shared package cluster_map_pkg:
  - ROWS and WIDTH constants.
  - SYNC_PATTERN 16'hAAAA.
  - TRAILER_MARK 11'h7FF.
  - FSM state enum (IDLE, HDR, ROWS, TRL).
  - Hit-count width (11).
- One sub-module: cluster_row_popcount, combinational WIDTH-bit popcount returning 6 bits, instantiated only under CLUSTER_MAP_TRAILER_EN.

## Test plan
- Single frame, macro on, ready=1:
  - Stimulus: header fiber id 10'h123, row 20 = 38'h1 and row 25 = 38'h3, all other rows zero.
  - Expected: 40 words. Word 0 = header with sof. Words 21 and 26 = the rows. Word 39 = trailer, value {1'b1, 11'h7FF, 10'h123, 5'b0, 11'd3}, with eof.
- Backpressure:
  - Stimulus: ready toggles 1/0 each cycle.
  - Expected: each word held stable while not ready. Frame completes in 80 cycles. Content matches the first test.
- Drop while busy:
  - Stimulus: second strobe 5 cycles after the first.
  - Expected: drop_cnt=1, only one frame output.
  - Stimulus: a strobe exactly at the eof handshake.
  - Expected: frame accepted, next header on the following cycle, drop_cnt unchanged.
- Reset mid-frame:
  - Stimulus: rst asserted at word 10.
  - Expected: dout_valid=0, busy=0, drop_cnt=0 next cycle. A new strobe then yields a full frame.
- Full map, macro on:
  - Stimulus: all 1444 bits set.
  - Expected: trailer [10:0]=11'd1444.
  - Macro off: 39 words, eof on row 37, no trailer.
- drop_cnt saturation:
  - Stimulus: 65537 strobes while ready held low.
  - Expected: drop_cnt=16'hFFFF.

Source files
------------

// File: rtl/cluster_map_pkg.sv
// cluster_map_pkg: constants, FSM state type and trailer builder shared by
// the cluster map serializer and its row popcount helper.
// Optional feature macro: CLUSTER_MAP_TRAILER_EN (hit counter + trailer word).
`timescale 1ns/1ps
package cluster_map_pkg;

  localparam int MAP_ROWS  = 38;
  localparam int MAP_WIDTH = 38;
  localparam int HIT_W     = 11;

  localparam logic [15:0] SYNC_PATTERN = 16'hAAAA;
  localparam logic [10:0] TRAILER_MARK = 11'h7FF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_ROWS,
    S_TRL
  } state_t;

  // Trailer: {mark bit, 11-bit marker, fiber id, 5'b0, hit count}.
  function automatic logic [MAP_WIDTH-1:0] make_trailer(input logic [9:0]       fid,
                                                        input logic [HIT_W-1:0] hits);
    return {1'b1, TRAILER_MARK, fid, 5'b0, hits};
  endfunction

endpackage

// File: rtl/cluster_row_popcount.sv
// cluster_row_popcount: combinational population count of one map row.
// Ports:
//   row   in  WIDTH  row bits
//   count out 6      number of set bits (WIDTH must be <= 63)
`timescale 1ns/1ps
module cluster_row_popcount #(
  parameter int WIDTH = 38
) (
  input  logic [WIDTH-1:0] row,
  output logic [5:0]       count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + 6'(row[i]);
    end
  end

endmodule

// File: rtl/cluster_map_serializer.sv
// cluster_map_serializer: captures a single-cycle hit-map frame (header plus
// ROWS rows) and streams it out one WIDTH-bit word per valid/ready handshake.
// Frames arriving while a frame is still streaming are dropped and counted.
// Optional feature macro: CLUSTER_MAP_TRAILER_EN adds a per-frame hit counter
// and a trailer word carrying it (eof moves from the last row to the trailer).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   map_hdr      mapper header, bit WIDTH-1 is the frame strobe
//   map_rows     flattened rows, row i at [WIDTH*i +: WIDTH]
//   dout         output word (zero when dout_valid is low)
//   dout_valid   word valid
//   dout_ready   downstream ready
//   dout_sof     high with the header word
//   dout_eof     high with the last word of the frame
//   busy         frame buffered and not fully sent
//   drop_cnt     dropped frame count, saturating
// The trailer layout assumes WIDTH == 38.
`timescale 1ns/1ps
module cluster_map_serializer
  import cluster_map_pkg::*;
#(
  parameter int ROWS  = MAP_ROWS,
  parameter int WIDTH = MAP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      map_hdr,
  input  logic [ROWS*WIDTH-1:0] map_rows,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_sof,
  output logic                  dout_eof,
  output logic                  busy,
  output logic [15:0]           drop_cnt
);

  localparam int               IDX_W    = $clog2(ROWS);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WIDTH-1:0]      hdr_q;
  logic [ROWS*WIDTH-1:0] rows_q;
  logic [WIDTH-1:0]      dout_d;
  logic                  sof_d, eof_d;
  logic                  strobe, hs, eof_hs, capture;

  function automatic logic [WIDTH-1:0] row_at(input logic [ROWS*WIDTH-1:0] r,
                                              input logic [IDX_W-1:0]      i);
    return r[int'(i)*WIDTH +: WIDTH];
  endfunction

  assign strobe  = map_hdr[WIDTH-1];
  assign hs      = dout_valid & dout_ready;
  assign eof_hs  = hs & dout_eof;
  // A new frame is taken when idle or exactly as the last word leaves.
  assign capture = strobe & (~busy | eof_hs);

`ifdef CLUSTER_MAP_TRAILER_EN
  logic [HIT_W-1:0] hits_q, hits_d;
  logic [WIDTH-1:0] cur_row;
  logic [5:0]       row_pop;

  assign cur_row = row_at(rows_q, idx_q);

  cluster_row_popcount #(.WIDTH(WIDTH)) u_pop (
    .row   (cur_row),
    .count (row_pop)
  );

  always_comb begin
    hits_d = hits_q;
    if (capture) begin
      hits_d = '0;
    end else if (state_q == S_ROWS && hs) begin
      hits_d = hits_q + HIT_W'(row_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q <= '0;
    end else begin
      hits_q <= hits_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (capture) state_d = S_HDR;
      S_HDR: begin
        if (hs) begin
          state_d = S_ROWS;
          idx_d   = '0;
        end
      end
      S_ROWS: begin
        if (hs) begin
          if (idx_q == LAST_ROW) begin
`ifdef CLUSTER_MAP_TRAILER_EN
            state_d = S_TRL;
`else
            state_d = capture ? S_HDR : S_IDLE;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_TRL: if (hs) state_d = capture ? S_HDR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    dout_d = '0;
    sof_d  = 1'b0;
    eof_d  = 1'b0;
    case (state_d)
      S_HDR: begin
        dout_d = capture ? map_hdr : hdr_q;
        sof_d  = 1'b1;
      end
      S_ROWS: begin
        dout_d = row_at(rows_q, idx_d);
`ifndef CLUSTER_MAP_TRAILER_EN
        eof_d  = (idx_d == LAST_ROW);
`endif
      end
`ifdef CLUSTER_MAP_TRAILER_EN
      S_TRL: begin
        dout_d = make_trailer(hdr_q[25:16], hits_d);
        eof_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hdr_q      <= '0;
      rows_q     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      busy       <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      if (capture) begin
        hdr_q  <= map_hdr;
        rows_q <= map_rows;
      end
      dout       <= dout_d;
      dout_valid <= (state_d != S_IDLE);
      busy       <= (state_d != S_IDLE);
      dout_sof   <= sof_d;
      dout_eof   <= eof_d;
      if (strobe && busy && !eof_hs && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cluster_map_serializer.sv
`timescale 1ns/1ps
module tb_cluster_map_serializer;

  localparam int ROWS  = 38;
  localparam int WIDTH = 38;
`ifdef CLUSTER_MAP_TRAILER_EN
  localparam bit HAS_TRL = 1'b1;
`else
  localparam bit HAS_TRL = 1'b0;
`endif
  localparam int NW = ROWS + 1 + int'(HAS_TRL);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [WIDTH-1:0]      map_hdr;
  logic [ROWS*WIDTH-1:0] map_rows;
  logic [WIDTH-1:0]      dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_sof;
  logic                  dout_eof;
  logic                  busy;
  logic [15:0]           drop_cnt;

  always #5 clk = ~clk;

  cluster_map_serializer #(.ROWS(ROWS), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .map_hdr    (map_hdr),
    .map_rows   (map_rows),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_sof   (dout_sof),
    .dout_eof   (dout_eof),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  typedef struct {
    logic [WIDTH-1:0] w;
    logic             sof;
    logic             eof;
  } word_t;

  word_t            exp_q[$];
  int               checks   = 0;
  int               errors   = 0;
  int               exp_drop = 0;
  logic [WIDTH-1:0] rows_m[ROWS];
  int               ncyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is the header, every row in order, then (with
  // the trailer feature) a word carrying the total number of set bits.
  task automatic drive_frame(input int pat, input logic [9:0] fid, input bit push);
    int               hits;
    logic [WIDTH-1:0] hdr;
    hits = 0;
    for (int i = 0; i < ROWS; i++) begin
      case (pat)
        0:       rows_m[i] = WIDTH'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
        1:       rows_m[i] = '1;
        default: rows_m[i] = (i == 20) ? 38'h1 : (i == 25) ? 38'h3 : 38'h0;
      endcase
      map_rows[i*WIDTH +: WIDTH] = rows_m[i];
      hits += $countones(rows_m[i]);
    end
    hdr     = {1'b1, 11'($urandom), fid, 16'hAAAA};
    map_hdr = hdr;
    if (push) begin
      exp_q.push_back('{w: hdr, sof: 1'b1, eof: 1'b0});
      for (int i = 0; i < ROWS; i++)
        exp_q.push_back('{w: rows_m[i], sof: 1'b0, eof: (!HAS_TRL && i == ROWS - 1)});
      if (HAS_TRL)
        exp_q.push_back('{w: {1'b1, 11'h7FF, fid, 5'b0, 11'(hits)}, sof: 1'b0, eof: 1'b1});
    end
  endtask

  task automatic start_frame(input int pat, input logic [9:0] fid);
    drive_frame(pat, fid, 1'b1);
    @(posedge clk); #1;
    map_hdr = '0;
  endtask

  // mode 0: ready high, 1: ready toggles starting low, 2: random ready.
  task automatic collect(input int mode, input int limit, input int inj_cyc,
                         input bit inj_eof, input int stop_after, output int cycles);
    int               cyc, hs_n;
    bit               r, hold, injected;
    logic [WIDTH-1:0] pd;
    logic             ps, pe;
    word_t            e;
    cyc = 0; hs_n = 0; hold = 0; injected = 0; cycles = 0;
    pd = '0; ps = 0; pe = 0;
    while (exp_q.size() > 0) begin
      if (cyc >= limit) begin
        chk("timeout_words_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        break;
      end
      map_hdr = '0;
      case (mode)
        0:       r = 1'b1;
        1:       r = cyc[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      dout_ready = r;
      if (hold) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_dout", dout, pd);
        chk("hold_sof", dout_sof, ps);
        chk("hold_eof", dout_eof, pe);
      end
      if (!dout_valid) chk("idle_dout_zero", dout, 0);
      if (cyc == inj_cyc) begin
        drive_frame(0, 10'h2AA, 1'b0);
        if (exp_q.size() > 0) exp_drop++;
      end
      if (dout_valid && r) begin
        e = exp_q.pop_front();
        chk("word", dout, e.w);
        chk("sof", dout_sof, e.sof);
        chk("eof", dout_eof, e.eof);
        hs_n++;
        cycles = cyc + 1;
        if (inj_eof && e.eof && !injected) begin
          drive_frame(0, 10'h155, 1'b1);
          injected = 1;
        end
      end
      hold = dout_valid && !r;
      pd = dout; ps = dout_sof; pe = dout_eof;
      @(posedge clk); #1;
      cyc++;
      if (stop_after > 0 && hs_n == stop_after) break;
    end
    map_hdr = '0;
  endtask

  initial begin
    rst = 1'b1; map_hdr = '0; map_rows = '0; dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_sof", dout_sof, 0);
    chk("rst_eof", dout_eof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed frame, ready high.
    start_frame(2, 10'h123);
    chk("hdr_latency_valid", dout_valid, 1);
    chk("hdr_latency_sof", dout_sof, 1);
    collect(0, 200, -1, 1'b0, 0, ncyc);
    chk("frame_cycles", 64'(ncyc), 64'(NW));
    chk("after_frame_valid", dout_valid, 0);
    chk("after_frame_busy", busy, 0);

    // Same frame under alternating backpressure.
    start_frame(2, 10'h123);
    collect(1, 300, -1, 1'b0, 0, ncyc);
    chk("bp_cycles", 64'(ncyc), 64'(2 * NW));

    // Strobe mid-frame is dropped.
    start_frame(0, 10'($urandom));
    collect(0, 200, 5, 1'b0, 0, ncyc);
    chk("drop_cnt_one", drop_cnt, 64'(exp_drop));
    repeat (3) @(posedge clk);
    #1;
    chk("drop_no_extra_frame", dout_valid, 0);

    // Strobe on the eof handshake is accepted with no gap.
    start_frame(0, 10'($urandom));
    collect(0, 300, -1, 1'b1, 0, ncyc);
    chk("b2b_cycles", 64'(ncyc), 64'(2 * NW));
    chk("b2b_drop_unchanged", drop_cnt, 64'(exp_drop));

    // Reset after ten words.
    start_frame(0, 10'($urandom));
    collect(0, 200, -1, 1'b0, 10, ncyc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    chk("midrst_valid", dout_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_drop", drop_cnt, 0);
    chk("midrst_dout", dout, 0);
    start_frame(0, 10'($urandom));
    collect(0, 200, -1, 1'b0, 0, ncyc);
    chk("postrst_cycles", 64'(ncyc), 64'(NW));

    // Strobe coincident with reset is not captured.
    rst = 1'b1;
    drive_frame(0, 10'h0F0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    map_hdr = '0;
    chk("strobe_rst_busy", busy, 0);
    @(posedge clk); #1;
    chk("strobe_rst_valid", dout_valid, 0);

    // Fully populated map.
    start_frame(1, 10'h3FF);
    collect(0, 200, -1, 1'b0, 0, ncyc);
    chk("full_cycles", 64'(ncyc), 64'(NW));

    // Random frames with random ready.
    for (int k = 0; k < 3; k++) begin
      start_frame(0, 10'($urandom));
      collect(2, 1000, -1, 1'b0, 0, ncyc);
    end
    chk("rand_idle", busy, 0);

    // Saturation: one capture then 65536 drops with ready low.
    dout_ready = 1'b0;
    drive_frame(0, 10'h001, 1'b0);
    repeat (65537) @(posedge clk);
    #1;
    map_hdr = '0;
    chk("drop_saturate", drop_cnt, 16'hFFFF);
    chk("sat_busy", busy, 1);
    chk("sat_hold_sof", dout_sof, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
